segre_mem_responder: RTL and testbench
======================================

SEGRE_MEM_RESPONDER -- requirements
Module: segre_mem_responder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter LATENCY, default 10, SHALL set the request-to-response delay in cycles; legal range 1..255.
REQ-003 Parameter MEM_LINES, default 1024, SHALL set storage depth in 128-bit lines; power of two.
REQ-004 Port clk_i  input  1  SHALL be the clock.
REQ-005 Port rst_ni  input  1  SHALL be the asynchronous active-low reset.
REQ-006 Port rd_req_i  input  1  SHALL request a line read (fill).
REQ-007 Port wr_req_i  input  1  SHALL request a line write (writeback).
REQ-008 Port req_src_i  input  1  SHALL tag the requester: 0 dcache, 1 icache.
REQ-009 Port addr_i  input  32  SHALL carry the byte address; bits [3:0] are ignored (line aligned).
REQ-010 Port wr_data_i  input  128  SHALL carry the writeback line.
REQ-011 Port rd_data_o  output  128  SHALL carry the fill line.
REQ-012 Port data_rdy_o  output  1  SHALL pulse for one cycle on completion of a read or write.
REQ-013 Port rsp_src_o  output  1  SHALL echo req_src_i of the completing request.
REQ-014 Port busy_o  output  1  SHALL be high while a request is in flight.
REQ-015 Port err_o  output  1  SHALL flag an out-of-range access (see Configuration).

Function
REQ-016 The FSM SHALL have states MEM_IDLE, MEM_BUSY and MEM_RESP.
REQ-017 In MEM_IDLE with rd_req_i or wr_req_i high, the block SHALL capture addr_i, wr_data_i, req_src_i and the op, load the counter with LATENCY-1, and go to MEM_BUSY.
REQ-018 When rd_req_i and wr_req_i are both high in MEM_IDLE, the write SHALL be accepted and the read ignored; the initiator re-issues the read.
REQ-019 Requests presented while not in MEM_IDLE SHALL be ignored, with no queuing.
REQ-020 In MEM_BUSY the counter SHALL decrement each cycle; at zero the access SHALL be performed and the FSM SHALL enter MEM_RESP.
REQ-021 In MEM_RESP, data_rdy_o SHALL be 1 for exactly one cycle, and the FSM SHALL return to MEM_IDLE on the next edge.
REQ-022 Timing: a request accepted at edge N SHALL produce data_rdy_o high during cycle N+LATENCY; the earliest next accept is at edge N+LATENCY+1.
REQ-023 busy_o SHALL equal (state != MEM_IDLE).
REQ-024 Line index SHALL be addr[4+log2(MEM_LINES)-1:4]; higher bits wrap, unless the Configuration feature is enabled.
REQ-025 On a read, rd_data_o SHALL update with the stored line in the data_rdy_o cycle and hold until the next read completes.
REQ-026 On a write, storage SHALL update in the data_rdy_o cycle, and rd_data_o SHALL be unchanged.
REQ-027 A read issued immediately after a write to the same line SHALL return the written data.

Reset
REQ-028 While rst_ni is low, the state SHALL be MEM_IDLE, the counter 0, and rd_data_o, data_rdy_o, rsp_src_o, busy_o and err_o all 0.
REQ-029 Reset asserted mid-request SHALL drop the request: no data_rdy_o pulse and no storage update.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 With SEGRE_MEM_ERR_EN defined, a request whose addr_i[31:4] >= MEM_LINES SHALL complete normally with err_o high alongside data_rdy_o, perform no storage write, and return rd_data_o = 0.
REQ-032 Without SEGRE_MEM_ERR_EN, err_o SHALL be tied 0 and addresses SHALL wrap per REQ-024.

Verification
REQ-033 LATENCY=10: rd_req_i at addr 0x40 with storage preloaded 0xA5..A5 -> data_rdy_o high exactly 10 cycles later, rd_data_o = 0xA5..A5, rsp_src_o matches req_src_i.
REQ-034 Write line 0x1122..FF to addr 0x80, then read 0x8C -> read returns 0x1122..FF; the write pulse occurs with rd_data_o unchanged.
REQ-035 rd_req_i and wr_req_i asserted together -> write performed, read ignored; a second rd_req_i held high during busy_o is not accepted until MEM_IDLE.
REQ-036 Reset pulsed at cycle 5 of a 10-cycle write -> no data_rdy_o, target line unchanged, all outputs 0.
REQ-037 SEGRE_MEM_ERR_EN defined, MEM_LINES=1024, read at addr 0x0001_0000 -> data_rdy_o=1, err_o=1, rd_data_o=0; without the macro -> wraps to line 0, err_o=0.
REQ-038 LATENCY=1 back-to-back reads -> data_rdy_o pulses every 2 cycles.

Source files
------------

// File: rtl/segre_mem_responder.sv
// Fixed-latency line memory model answering dcache/icache fills and writebacks.
// Optional build macro SEGRE_MEM_ERR_EN flags out-of-range lines instead of wrapping.
module segre_mem_responder #(
    parameter int LATENCY   = 10,
    parameter int MEM_LINES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         rd_req_i,
    input  logic         wr_req_i,
    input  logic         req_src_i,
    input  logic [31:0]  addr_i,
    input  logic [127:0] wr_data_i,
    output logic [127:0] rd_data_o,
    output logic         data_rdy_o,
    output logic         rsp_src_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam int IDX_W = $clog2(MEM_LINES);

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [27:0]    line_q;
    logic [127:0]   wdata_q;
    logic [127:0]   rd_data_q;
    logic           src_q;
    logic           op_wr_q;
    logic           accept;
    logic           do_access;
    logic           oor;
    logic           mem_we;
    logic [IDX_W-1:0] idx;

    logic [127:0]   mem_q [MEM_LINES];

    assign idx       = line_q[IDX_W-1:0];
    assign do_access = (state_q == MEM_BUSY) && (cnt_q == 8'd0);

`ifdef SEGRE_MEM_ERR_EN
    assign oor = ({4'b0, line_q} >= 32'(MEM_LINES));
    logic unused_addr;
    assign unused_addr = ^addr_i[3:0];
`else
    assign oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr_i[3:0], line_q};
`endif

    assign mem_we = do_access && op_wr_q && !oor;

    // The RESP cycle doubles as an accept slot so the next request can be
    // taken on the edge that ends the response (accept-to-accept = LATENCY+1).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            MEM_IDLE, MEM_RESP: begin
                state_d = MEM_IDLE;
                if (rd_req_i || wr_req_i) begin
                    accept  = 1'b1;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= 8'd0;
            line_q    <= '0;
            wdata_q   <= '0;
            src_q     <= 1'b0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                line_q  <= addr_i[31:4];
                wdata_q <= wr_data_i;
                src_q   <= req_src_i;
                op_wr_q <= wr_req_i;    // write wins when both are requested
            end
            if (do_access && !op_wr_q) begin
                rd_data_q <= oor ? '0 : mem_q[idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign data_rdy_o = (state_q == MEM_RESP);
    assign rsp_src_o  = src_q;
    assign busy_o     = (state_q != MEM_IDLE);

`ifdef SEGRE_MEM_ERR_EN
    assign err_o = (state_q == MEM_RESP) && oor;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_segre_mem_responder.sv
// Directed bench for segre_mem_responder: LATENCY=10 main instance plus a LATENCY=1 instance.
module tb_segre_mem_responder;

    logic         clk;
    logic         rst_n;
    logic         rd_req, wr_req, req_src;
    logic [31:0]  addr;
    logic [127:0] wr_data;
    logic [127:0] rd_data;
    logic         data_rdy, rsp_src, busy, err;

    logic         rd_req1, wr_req1;
    logic [31:0]  addr1;
    logic [127:0] wr_data1;
    logic [127:0] rd_data1;
    logic         data_rdy1, rsp_src1, busy1, err1;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_11 = 128'h112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PAT_D  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] PAT_Z  = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
    localparam logic [127:0] PAT_N  = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;
    localparam logic [127:0] PAT_L1 = 128'h00000001_00000002_00000003_00000004;

    segre_mem_responder #(.LATENCY(10), .MEM_LINES(1024)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .req_src_i(req_src), .addr_i(addr), .wr_data_i(wr_data),
        .rd_data_o(rd_data), .data_rdy_o(data_rdy), .rsp_src_o(rsp_src),
        .busy_o(busy), .err_o(err)
    );

    segre_mem_responder #(.LATENCY(1), .MEM_LINES(1024)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req1), .wr_req_i(wr_req1),
        .req_src_i(1'b0), .addr_i(addr1), .wr_data_i(wr_data1),
        .rd_data_o(rd_data1), .data_rdy_o(data_rdy1), .rsp_src_o(rsp_src1),
        .busy_o(busy1), .err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Present one request for exactly one accept edge; returns at the negedge after it.
    task automatic issue(input logic rd, input logic wr, input logic src,
                         input logic [31:0] a, input logic [127:0] d);
        @(negedge clk);
        rd_req = rd; wr_req = wr; req_src = src; addr = a; wr_data = d;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    // Counts accept-relative cycles until data_rdy is seen (99 = timed out).
    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!data_rdy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!data_rdy) lat = 99;
    endtask

    task automatic wait_rdy1(output int lat);
        lat = 0;
        @(negedge clk);
        lat++;
        while (!data_rdy1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!data_rdy1) lat = 99;
    endtask

    int lat;
    int pulses;
    logic [127:0] held;

    initial begin
        rst_n = 1'b0; rd_req = 0; wr_req = 0; req_src = 0; addr = '0; wr_data = '0;
        rd_req1 = 0; wr_req1 = 0; addr1 = '0; wr_data1 = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_rdy", 128'(data_rdy), 128'd0);
        check_val("rst_rd_data", rd_data, 128'd0);
        check_val("rst_src", 128'(rsp_src), 128'd0);
        check_val("rst_err", 128'(err), 128'd0);
        rst_n = 1'b1;

        // preload line 4 then read it back from the icache side
        issue(1'b0, 1'b1, 1'b0, 32'h40, PAT_A5);
        check_val("wr40_busy", 128'(busy), 128'd1);
        wait_rdy(lat);
        check_val("wr40_lat", 128'(lat), 128'd10);
        check_val("wr40_rd_data_unchanged", rd_data, 128'd0);
        check_val("wr40_err", 128'(err), 128'd0);

        issue(1'b1, 1'b0, 1'b1, 32'h40, 128'd0);
        wait_rdy(lat);
        check_val("rd40_lat", 128'(lat), 128'd10);
        check_val("rd40_data", rd_data, PAT_A5);
        check_val("rd40_src", 128'(rsp_src), 128'd1);

        // write then read same line via a different in-line offset
        issue(1'b0, 1'b1, 1'b0, 32'h80, PAT_11);
        wait_rdy(lat);
        check_val("wr80_lat", 128'(lat), 128'd10);
        check_val("wr80_rd_data_unchanged", rd_data, PAT_A5);
        issue(1'b1, 1'b0, 1'b0, 32'h8C, 128'd0);
        wait_rdy(lat);
        check_val("rd8c_lat", 128'(lat), 128'd10);
        check_val("rd8c_data", rd_data, PAT_11);
        check_val("rd8c_src", 128'(rsp_src), 128'd0);

        // simultaneous read+write: the write wins
        issue(1'b1, 1'b1, 1'b1, 32'h100, PAT_D);
        wait_rdy(lat);
        check_val("rw_lat", 128'(lat), 128'd10);
        check_val("rw_rd_data_unchanged", rd_data, PAT_11);
        check_val("rw_src", 128'(rsp_src), 128'd1);
        issue(1'b1, 1'b0, 1'b0, 32'h100, 128'd0);
        wait_rdy(lat);
        check_val("rd100_data", rd_data, PAT_D);

        // read held high: only re-accepted once the response cycle ends
        @(negedge clk);
        rd_req = 1'b1; req_src = 1'b0; addr = 32'h80;
        @(negedge clk);
        wait_rdy(lat);
        check_val("hold_first_lat", 128'(lat), 128'd10);
        check_val("hold_first_data", rd_data, PAT_11);
        @(negedge clk);
        lat = 1;
        while (!data_rdy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd_req = 1'b0;
        check_val("hold_gap", 128'(lat), 128'd11);

        // reset 5 cycles into a write: dropped, line 4 keeps A5
        issue(1'b0, 1'b1, 1'b0, 32'h40, PAT_N);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", 128'(busy), 128'd0);
        check_val("midrst_rdy", 128'(data_rdy), 128'd0);
        check_val("midrst_rd_data", rd_data, 128'd0);
        check_val("midrst_err", 128'(err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (data_rdy) pulses++;
        end
        check_val("midrst_no_pulse", 128'(pulses), 128'd0);
        issue(1'b1, 1'b0, 1'b0, 32'h40, 128'd0);
        wait_rdy(lat);
        check_val("midrst_line_kept", rd_data, PAT_A5);

        // high address: wraps to line 0 or flags an error
        issue(1'b0, 1'b1, 1'b0, 32'h0, PAT_Z);
        wait_rdy(lat);
        issue(1'b1, 1'b0, 1'b0, 32'h0001_0000, 128'd0);
        wait_rdy(lat);
        check_val("hi_lat", 128'(lat), 128'd10);
`ifdef SEGRE_MEM_ERR_EN
        check_val("hi_err", 128'(err), 128'd1);
        check_val("hi_data", rd_data, 128'd0);
`else
        check_val("hi_err", 128'(err), 128'd0);
        check_val("hi_data", rd_data, PAT_Z);
`endif
        @(negedge clk);
        check_val("hi_err_after", 128'(err), 128'd0);

        // LATENCY=1 instance: back-to-back reads every 2 cycles
        @(negedge clk);
        wr_req1 = 1'b1; addr1 = 32'h30; wr_data1 = PAT_L1;
        wait_rdy1(lat);
        wr_req1 = 1'b0;
        check_val("l1_wr_lat", 128'(lat), 128'd2);
        @(negedge clk);
        rd_req1 = 1'b1;
        wait_rdy1(lat);
        check_val("l1_first_lat", 128'(lat), 128'd2);
        check_val("l1_data", rd_data1, PAT_L1);
        held = rd_data1;
        for (int k = 0; k < 2; k++) begin
            wait_rdy1(lat);
            check_val($sformatf("l1_gap%0d", k), 128'(lat), 128'd2);
        end
        rd_req1 = 1'b0;
        check_val("l1_data_hold", rd_data1, held);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
